dense_vec_packer: RTL and testbench
===================================

Name: dense_vec_packer

Overview:
- Serial-to-parallel front end for the dense layers. It accepts one fixed-point element per handshake and assembles NB_ELEM elements into the packed input bus that dense1 consumes (42 x 32 by default).
- It then holds that vector stable, with a valid/ready handshake, until the dense stage takes it.
- It sits between the feature-extraction stream and dense1. With NB_ELEM=24 or 96 the same block feeds dense2 or dense3.

Parameters:
- FIXED, 32, width of one fixed-point element in bits.
- NB_ELEM, 42, number of elements per packed vector.
- IDX_W, 6, width of the element index counter; must satisfy 2**IDX_W >= NB_ELEM.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_valid  input  1  input element valid.
- s_ready  output  1  packer can accept an element this cycle.
- s_data  input  FIXED  input element.
- s_last  input  1  marks the final element of a vector.
- m_valid  output  1  packed vector is available.
- m_ready  input  1  downstream dense stage takes the vector.
- m_data  output  NB_ELEM*FIXED  packed vector; element k sits at bits [k*FIXED +: FIXED].
- err_len  output  1  one-cycle pulse on a vector-length violation.

Behaviour:
- Reset (async, while rst_n=0): state=FILL, idx=0, m_valid=0, err_len=0, m_data=0. s_ready=0 while rst_n=0, and 1 from the first cycle after release.
- Reset mid-fill or while FULL discards all partial or held data. No vector is emitted.
- State FILL:
  - s_ready=1 and m_valid=0.
  - Accept when s_valid&&s_ready: write s_data into slot idx.
  - idx<NB_ELEM-1 and s_last=0: idx<=idx+1.
  - idx<NB_ELEM-1 and s_last=1: short vector. err_len pulses the next cycle, idx<=0, stay in FILL. The partial vector is dropped; stale slots may remain in m_data but m_valid stays 0.
  - idx==NB_ELEM-1: go to FULL, idx<=0, m_valid=1 on the next cycle. If s_last=0 on this element (long/unterminated vector), err_len also pulses the next cycle, but the vector is still emitted.
- State FULL:
  - s_ready=0, m_valid=1, m_data held bit-stable.
  - On m_valid&&m_ready: go to FILL, m_valid=0 and s_ready=1 on the next cycle.
  - m_ready while m_valid=0 has no effect.
- Latency: m_valid rises exactly 1 cycle after the final element is accepted.
- Throughput without the option: NB_ELEM+1 cycles per vector minimum; the cycle after m_ready is a fill-resume cycle.
- m_data is a register; there is no combinational path from s_data to m_data.
- err_len is a registered single-cycle pulse. Back-to-back errors give back-to-back pulses.
- The block performs no arithmetic; data is copied bit-exact with no sign or scale changes.

Optional Feature:
- Macro: DENSE_VEC_DOUBLE_BUF_EN.
- When defined: two banks in ping-pong operation.
  - Filling continues into the free bank while the other bank is presented on m_data.
  - s_ready=0 only when both banks are full.
  - Vectors are emitted strictly in fill order.
  - On a simultaneous final-element accept and m_ready, the presented bank is released and the just-filled bank is presented the next cycle, with m_valid staying 1.
  - Sustained throughput is 1 element per cycle.
- When undefined: single bank, behaviour exactly as above.

Decomposition:
- Shared package dense_pkg:
  - FIXED=32.
  - Layer sizes: DENSE1_IN=42, DENSE1_OUT=24, DENSE2_IN=24, DENSE3_IN=96, DENSE3_OUT=22.
  - typedef fixed_t (logic [FIXED-1:0]).
  - Packer state enum {FILL, FULL}.
- Sub-module dense_vec_bank: one NB_ELEM*FIXED register bank with write-enable and index. It is instantiated once, or twice under DENSE_VEC_DOUBLE_BUF_EN.

Test Plan:
- Basic fill: send 42 elements 0x00000001..0x0000002A, s_last on the 42nd, m_ready=1 throughout.
  - m_valid rises 1 cycle after the 42nd accept.
  - m_data[0 +: 32]=0x1 and m_data[41*32 +: 32]=0x2A.
  - m_valid falls the next cycle; err_len never asserts.
- Backpressure: hold m_ready=0 for 10 cycles after the vector is full, driving s_valid=1 with data 0xDEADBEEF.
  - s_ready=0 throughout and m_data unchanged.
  - After m_ready=1, the first element accepted into slot 0 is 0xDEADBEEF.
- Short vector: s_last on element 5 (idx=4).
  - err_len pulses for 1 cycle; m_valid stays 0.
  - A following full 42-element vector is emitted correctly.
- Missing s_last: 42 elements, none with s_last.
  - Vector emitted and err_len pulses once, 1 cycle after the 42nd accept.
- Reset mid-fill: assert rst_n=0 asynchronously (mid-cycle) after 20 elements.
  - m_valid=0, s_ready=0 and m_data=0 immediately.
  - After release, a 42-element vector is emitted with no trace of the old data.
- With DENSE_VEC_DOUBLE_BUF_EN: stream 84 elements back-to-back with m_ready=1.
  - s_ready stays 1 throughout.
  - Two vectors are emitted in order; the second m_valid rises exactly 42 cycles after the first.

Source files
------------

// File: rtl/dense_pkg.sv
// Shared constants and types for the dense-layer front end: element width, layer sizes, packer state.
package dense_pkg;

  localparam int FIXED      = 32;
  localparam int DENSE1_IN  = 42;
  localparam int DENSE1_OUT = 24;
  localparam int DENSE2_IN  = 24;
  localparam int DENSE3_IN  = 96;
  localparam int DENSE3_OUT = 22;

  typedef logic [FIXED-1:0] fixed_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } pack_state_e;

endpackage

// File: rtl/dense_vec_bank.sv
// One NB_ELEM x FIXED register bank; writes one element per enabled cycle at wr_idx.
// Output is the registered bank contents, cleared by reset.
module dense_vec_bank #(
  parameter int FIXED   = 32,
  parameter int NB_ELEM = 42,
  parameter int IDX_W   = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [FIXED-1:0]         wr_dat,
  output logic [NB_ELEM*FIXED-1:0] rd_dat
);

  logic [NB_ELEM-1:0][FIXED-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      data_d[wr_idx] = wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign rd_dat = data_q;

endmodule

// File: rtl/dense_vec_packer.sv
// Serial-to-parallel packer: NB_ELEM elements -> one held vector with valid/ready, 1-cycle latency.
// DENSE_VEC_DOUBLE_BUF_EN selects ping-pong banks so filling continues while a vector is presented.
module dense_vec_packer #(
  parameter int FIXED   = dense_pkg::FIXED,
  parameter int NB_ELEM = dense_pkg::DENSE1_IN,
  parameter int IDX_W   = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [FIXED-1:0]         s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [NB_ELEM*FIXED-1:0] m_data,
  output logic                     err_len
);

  import dense_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_ELEM - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic             live_q, live_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             accept;
  logic             last_slot;

  assign accept    = s_valid && s_ready;
  assign last_slot = (idx_q == LAST_IDX);
  // s_ready stays low until the first clock edge after reset release
  assign live_d    = 1'b1;
  assign err_len   = err_q;

  always_comb begin
    idx_d = idx_q;
    err_d = 1'b0;
    if (accept) begin
      if (last_slot) begin
        idx_d = '0;
        err_d = !s_last;
      end else if (s_last) begin
        idx_d = '0;
        err_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= 1'b0;
      idx_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      live_q <= live_d;
      idx_q  <= idx_d;
      err_q  <= err_d;
    end
  end

`ifdef DENSE_VEC_DOUBLE_BUF_EN

  logic [1:0]               full_q, full_d;
  logic                     wr_bank_q, wr_bank_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [NB_ELEM*FIXED-1:0] bank_dat [2];

  // the fill bank is only full when both banks are occupied
  assign s_ready = live_q && !full_q[wr_bank_q];
  assign m_valid = full_q[rd_bank_q];
  assign m_data  = bank_dat[rd_bank_q];

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (m_valid && m_ready) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
    if (accept && last_slot) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dense_vec_bank #(
      .FIXED   (FIXED),
      .NB_ELEM (NB_ELEM),
      .IDX_W   (IDX_W)
    ) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (accept && (wr_bank_q == 1'(b))),
      .wr_idx (idx_q),
      .wr_dat (s_data),
      .rd_dat (bank_dat[b])
    );
  end

`else

  pack_state_e              state_q, state_d;
  logic [NB_ELEM*FIXED-1:0] bank_dat;

  assign s_ready = live_q && (state_q == FILL);
  assign m_valid = (state_q == FULL);
  assign m_data  = bank_dat;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (accept && last_slot) state_d = FULL;
      FULL:    if (m_ready)             state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  dense_vec_bank #(
    .FIXED   (FIXED),
    .NB_ELEM (NB_ELEM),
    .IDX_W   (IDX_W)
  ) u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (accept),
    .wr_idx (idx_q),
    .wr_dat (s_data),
    .rd_dat (bank_dat)
  );

`endif

endmodule

// File: tb/tb_dense_vec_packer.sv
// Bench for dense_vec_packer: vector table, hand sequences for backpressure/reset, random stream vs model.
module tb_dense_vec_packer;

  localparam int FIXED = 32;
  localparam int NB    = 42;
  localparam int W     = NB * FIXED;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [FIXED-1:0] s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [W-1:0]     m_data;
  logic             err_len;

  dense_vec_packer #(.FIXED(FIXED), .NB_ELEM(NB), .IDX_W(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .err_len (err_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // reference model: element count of the vector under construction plus expected outputs
  int           model_cnt = 0;
  logic [W-1:0] model_vec;
  logic [W-1:0] expq [$];
  int           exp_err = 0;

  // observation state
  int           err_seen = 0, err_cyc = -1, rise_cyc = -1, fall_cyc = -1;
  int           emitted = 0, acc_cyc = -1, wait_cnt = 0;
  int           rise_q [$];
  logic         mv_prev = 1'b0, took_prev = 1'b0;
  logic [W-1:0] prev_dat, last_vec;
  bit           rand_rdy = 1'b0;

  typedef struct {
    int          n;
    int          last_at;
    logic [31:0] base;
    int          exp_vec;
    int          exp_err;
  } vec_rec_t;

  vec_rec_t tbl [6];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_push(input logic [31:0] d, input bit last);
    model_vec[model_cnt*FIXED +: FIXED] = d;
    model_cnt++;
    if (model_cnt == NB) begin
      expq.push_back(model_vec);
      if (!last) exp_err++;
      model_cnt = 0;
    end else if (last) begin
      exp_err++;
      model_cnt = 0;
    end
  endtask

  task automatic sample();
    logic [W-1:0] ev;
    if (!rst_n) begin
      mv_prev = 1'b0;
      took_prev = 1'b0;
      return;
    end
    if (m_valid && !mv_prev) begin
      rise_cyc = cyc;
      rise_q.push_back(cyc);
    end
    if (!m_valid && mv_prev) fall_cyc = cyc;
    if (err_len) begin
      err_seen++;
      err_cyc = cyc;
    end
    if (mv_prev && !took_prev && m_valid) chk("hold_stable", longint'(m_data == prev_dat), 1);
    took_prev = m_valid && m_ready;
    if (took_prev) begin
      emitted++;
      last_vec = m_data;
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL vec_unexpected got=1 exp=0");
      end else begin
        ev = expq.pop_front();
        if (m_data !== ev) begin
          failures++;
          for (int k = 0; k < NB; k++) begin
            if (m_data[k*FIXED +: FIXED] !== ev[k*FIXED +: FIXED]) begin
              $display("FAIL vec_data slot=%0d got=0x%08h exp=0x%08h", k,
                       m_data[k*FIXED +: FIXED], ev[k*FIXED +: FIXED]);
              break;
            end
          end
        end
      end
    end
    mv_prev  = m_valid;
    prev_dat = m_data;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input logic [31:0] d, input bit last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && n < 500) begin
      tick();
      n++;
    end
    wait_cnt = n;
    if (n >= 500) begin
      chk("push_timeout", n, 0);
    end else begin
      tick();
      acc_cyc = cyc;
      model_push(d, last);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    m_ready = 1'b1;
    while ((expq.size() != 0 || m_valid) && n < 2000) begin
      tick();
      n++;
    end
    repeat (2) tick();
    chk("drain_done", longint'(n < 2000), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=1 exp=0");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int e0, r0, len;
    bit lst;
    logic [W-1:0] held;

    tbl[0] = '{n: 42, last_at: 41, base: 32'h1,        exp_vec: 1, exp_err: 0};
    tbl[1] = '{n: 5,  last_at: 4,  base: 32'h100,      exp_vec: 0, exp_err: 1};
    tbl[2] = '{n: 42, last_at: 41, base: 32'h8000_0000, exp_vec: 1, exp_err: 0};
    tbl[3] = '{n: 42, last_at: -1, base: 32'hFFFF_FFF0, exp_vec: 1, exp_err: 1};
    tbl[4] = '{n: 1,  last_at: 0,  base: 32'h55,       exp_vec: 0, exp_err: 1};
    tbl[5] = '{n: 41, last_at: 40, base: 32'h200,      exp_vec: 0, exp_err: 1};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    #13;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_m_data_zero", longint'(m_data == '0), 1);
    #9 rst_n = 1'b1;
    chk("rel_s_ready_before_edge", s_ready, 0);
    @(posedge clk); #1;
    chk("rel_s_ready_after_edge", s_ready, 1);

    for (int i = 0; i < 6; i++) begin
      e0 = emitted; r0 = err_seen; rise_cyc = -1; fall_cyc = -1; err_cyc = -1;
      for (int j = 0; j < tbl[i].n; j++) push(tbl[i].base + 32'(j), j == tbl[i].last_at);
      repeat (3) tick();
      chk($sformatf("rec%0d_emitted", i), emitted - e0, tbl[i].exp_vec);
      chk($sformatf("rec%0d_err", i), err_seen - r0, tbl[i].exp_err);
      if (tbl[i].exp_vec != 0) begin
        chk($sformatf("rec%0d_rise_lat", i), rise_cyc, acc_cyc);
        chk($sformatf("rec%0d_fall", i), fall_cyc, acc_cyc + 1);
      end
      if (tbl[i].exp_err != 0) chk($sformatf("rec%0d_err_cyc", i), err_cyc, acc_cyc);
      if (i == 0) begin
        chk("basic_slot0", last_vec[0 +: 32], 32'h1);
        chk("basic_slot41", last_vec[41*32 +: 32], 32'h2A);
      end
    end

`ifndef DENSE_VEC_DOUBLE_BUF_EN
    m_ready = 1'b0;
    for (int j = 0; j < NB; j++) push(32'h300 + 32'(j), j == NB - 1);
    tick();
    held = m_data;
    s_valid = 1'b1; s_data = 32'hDEADBEEF; s_last = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("bp_s_ready", s_ready, 0);
      chk("bp_m_data_held", longint'(m_data == held), 1);
      tick();
    end
    m_ready = 1'b1;
    push(32'hDEADBEEF, 1'b0);
    chk("bp_slot0_written", m_data[0 +: 32], 32'hDEADBEEF);
    for (int j = 1; j < NB; j++) push(32'h400 + 32'(j), j == NB - 1);
    repeat (3) tick();
    chk("bp_vec_slot0", last_vec[0 +: 32], 32'hDEADBEEF);
`endif

    for (int j = 0; j < 20; j++) push(32'hBAD0_0000 + 32'(j), 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_m_data_zero", longint'(m_data == '0), 1);
    model_cnt = 0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    e0 = emitted;
    for (int j = 0; j < NB; j++) push(32'h6000 + 32'(j), j == NB - 1);
    repeat (3) tick();
    chk("post_rst_emitted", emitted - e0, 1);

    rand_rdy = 1'b1;
    for (int v = 0; v < 25; v++) begin
      if ($urandom_range(0, 3) == 0) begin
        len = $urandom_range(1, NB - 1);
        lst = 1'b1;
      end else begin
        len = NB;
        lst = ($urandom_range(0, 4) != 0);
      end
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
        push($urandom, (j == len - 1) ? lst : 1'b0);
      end
    end
    rand_rdy = 1'b0;
    drain();
    chk("rand_queue_empty", expq.size(), 0);
    chk("err_total", err_seen, exp_err);

`ifdef DENSE_VEC_DOUBLE_BUF_EN
    rise_q.delete();
    m_ready = 1'b1;
    for (int j = 0; j < 2 * NB; j++) begin
      push(32'h7000 + 32'(j), (j % NB) == NB - 1);
      chk("db_s_ready_no_wait", wait_cnt, 0);
    end
    repeat (3) tick();
    chk("db_two_vectors", rise_q.size(), 2);
    if (rise_q.size() == 2) chk("db_spacing", rise_q[1] - rise_q[0], NB);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
